prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 141 ++++++++++++++
 tb/tb_prbs_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) parallel checker: seeds from the received stream, then counts bit errors.
// Optional feature: define PRBS_AUTO_RELOCK_EN to reseed automatically after a run of badly-errored words.

module prbs_checker #(
  parameter int Nti   = 16,
  parameter int Nprbs = 7,
  parameter int Nerr  = 32,
  parameter int Nbit  = 40
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            en,
  input  logic            clear,
  input  logic            rx_valid,
  input  logic [Nti-1:0]  rx_bits,
  output logic            locked,
  output logic            err_flag,
  output logic [Nerr-1:0] err_cnt,
  output logic [Nbit-1:0] bit_cnt
);

  localparam int PopW    = $clog2(Nti + 1);
  localparam int ErrSumW = ((Nerr > PopW) ? Nerr : PopW) + 1;
  localparam int BitSumW = ((Nbit > PopW) ? Nbit : PopW) + 1;

  typedef enum logic [1:0] {IDLE, SEED, CHECK} state_t;

  state_t              state;
  logic [Nprbs-1:0]    hist;
  logic [Nprbs-1:0]    next_hist;
  logic [Nti-1:0]      exp_word;
  logic [Nti-1:0]      err_word;
  logic [PopW-1:0]     err_pop;
  logic [ErrSumW-1:0]  err_sum;
  logic [BitSumW-1:0]  bit_sum;
  logic [Nerr-1:0]     err_next;
  logic [Nbit-1:0]     bit_next;
  logic                do_check;

  // The expected word extends the history bit by bit; the history then advances
  // from these expected bits, so a received error never pollutes the reference.
  always_comb begin : gen_expected
    logic [Nprbs+Nti-1:0] seq;
    // NOTE: every variable gets a full default before any partial update, so no latch can be inferred.
    seq = '0;
    seq[Nprbs-1:0] = hist;
    for (int i = 0; i < Nti; i++) begin
      seq[Nprbs+i] = seq[i] ^ seq[i+1];
    end
    exp_word  = seq[Nprbs+Nti-1:Nprbs];
    next_hist = seq[Nprbs+Nti-1:Nti];
  end

  assign err_word = rx_bits ^ exp_word;
  assign err_pop  = PopW'($countones(err_word));
  assign do_check = en && (state == CHECK) && rx_valid;

  // One spare carry bit in each sum detects overflow for saturation.
  assign err_sum  = ErrSumW'(err_cnt) + ErrSumW'(err_pop);
  assign bit_sum  = BitSumW'(bit_cnt) + BitSumW'(Nti);
  assign err_next = (|err_sum[ErrSumW-1:Nerr]) ? '1 : err_sum[Nerr-1:0];
  assign bit_next = (|bit_sum[BitSumW-1:Nbit]) ? '1 : bit_sum[Nbit-1:0];

`ifdef PRBS_AUTO_RELOCK_EN
  logic [1:0] bad_run;
  logic       bad_word;
  assign bad_word = err_pop >= PopW'(Nti / 4);
`endif

  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (!rstb) begin
      state    <= IDLE;
      hist     <= '0;
      locked   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
`ifdef PRBS_AUTO_RELOCK_EN
      bad_run  <= '0;
`endif
    end else begin
      err_flag <= 1'b0;

      if (clear) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else if (do_check) begin
        err_cnt <= err_next;
        bit_cnt <= bit_next;
      end

      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
`ifdef PRBS_AUTO_RELOCK_EN
        bad_run <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state  <= SEED;
            locked <= 1'b0;
          end
          SEED: begin
            if (rx_valid) begin
              hist   <= rx_bits[Nti-1 -: Nprbs];
              state  <= CHECK;
              locked <= 1'b1;
`ifdef PRBS_AUTO_RELOCK_EN
              bad_run <= '0;
`endif
            end
          end
          CHECK: begin
            if (rx_valid) begin
              hist     <= next_hist;
              err_flag <= |err_word;
`ifdef PRBS_AUTO_RELOCK_EN
              if (!bad_word) begin
                bad_run <= '0;
              end else if (bad_run == 2'd3) begin
                bad_run <= '0;
                state   <= SEED;
                locked  <= 1'b0;
              end else begin
                bad_run <= bad_run + 2'd1;
              end
`endif
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed table, hand-written corner sequences and
// randomized PRBS7 traffic compared against a queue-based behavioural model.

module tb_prbs_checker;

  localparam int Nti = 16;

  logic        clk = 1'b0;
  logic        rstb, en, clear, rx_valid;
  logic [15:0] rx_bits;
  logic        locked, err_flag, s_locked, s_err_flag;
  logic [31:0] err_cnt;
  logic [39:0] bit_cnt;
  logic [3:0]  s_err_cnt;
  logic [5:0]  s_bit_cnt;

  prbs_checker dut (
    .clk(clk), .rstb(rstb), .en(en), .clear(clear), .rx_valid(rx_valid), .rx_bits(rx_bits),
    .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  // Narrow counters so saturation is reachable in a short run.
  prbs_checker #(.Nti(16), .Nprbs(7), .Nerr(4), .Nbit(6)) dut_small (
    .clk(clk), .rstb(rstb), .en(en), .clear(clear), .rx_valid(rx_valid), .rx_bits(rx_bits),
    .locked(s_locked), .err_flag(s_err_flag), .err_cnt(s_err_cnt), .bit_cnt(s_bit_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_SEED, M_CHECK} mode_t;
  localparam longint ErrMax  = (64'd1 << 32) - 1;
  localparam longint BitMax  = (64'd1 << 40) - 1;
  localparam longint SErrMax = 15;
  localparam longint SBitMax = 63;

  mode_t  m_mode;
  bit     m_hist[$];
  int     m_run;
  bit     m_locked, m_flag;
  longint m_err, m_bits, ms_err, ms_bits;

  function automatic longint sat_add(longint a, longint b, longint mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_hist.delete();
    for (int j = 0; j < 7; j++) m_hist.push_back(1'b0);
    m_run = 0; m_locked = 0; m_flag = 0;
    m_err = 0; m_bits = 0; ms_err = 0; ms_bits = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input bit v, input logic [15:0] b);
    int pc = 0;
    bit chk = 0;
    bit q[$];
    if (!e) begin
      m_mode = M_IDLE;
      m_run  = 0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_SEED;
        M_SEED: if (v) begin
          m_hist.delete();
          for (int j = 0; j < 7; j++) m_hist.push_back(b[Nti-7+j]);
          m_mode = M_CHECK;
          m_run  = 0;
        end
        M_CHECK: if (v) begin
          q = m_hist;
          for (int i = 0; i < Nti; i++) begin
            bit x;
            x = q[q.size()-7] ^ q[q.size()-6];
            q.push_back(x);
            if (x != b[i]) pc++;
          end
          while (q.size() > 7) void'(q.pop_front());
          m_hist = q;
          chk = 1;
`ifdef PRBS_AUTO_RELOCK_EN
          if (pc >= Nti / 4) begin
            m_run++;
            if (m_run == 4) begin
              m_mode = M_SEED;
              m_run  = 0;
            end
          end else begin
            m_run = 0;
          end
`endif
        end
        default: m_mode = M_IDLE;
      endcase
    end
    if (c) begin
      m_err = 0; m_bits = 0; ms_err = 0; ms_bits = 0;
    end else if (chk) begin
      m_err   = sat_add(m_err, pc, ErrMax);
      m_bits  = sat_add(m_bits, Nti, BitMax);
      ms_err  = sat_add(ms_err, pc, SErrMax);
      ms_bits = sat_add(ms_bits, Nti, SBitMax);
    end
    m_locked = (m_mode == M_CHECK);
    m_flag   = chk && (pc != 0);
  endtask

  task automatic compare_model();
    check("locked", locked, m_locked);
    check("err_flag", err_flag, m_flag);
    check("err_cnt", err_cnt, m_err);
    check("bit_cnt", bit_cnt, m_bits);
    check("small_locked", s_locked, m_locked);
    check("small_err_cnt", s_err_cnt, ms_err);
    check("small_bit_cnt", s_bit_cnt, ms_bits);
  endtask

  // ---------------- stimulus helpers ----------------
  logic [6:0] g;  // generator state, g[0] is the oldest bit

  task automatic gen_word(output logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      logic nb;
      nb = g[0] ^ g[1];
      g  = {nb, g[6:1]};
      w[i] = nb;
    end
  endtask

  task automatic cycle(input bit e, input bit c, input bit v, input logic [15:0] b);
    en = e; clear = c; rx_valid = v; rx_bits = b;
    @(posedge clk);
    model_step(e, c, v, b);
    @(negedge clk);
    compare_model();
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    rstb = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_small_err_cnt", s_err_cnt, 0);
    model_reset();
    en = 0; clear = 0; rx_valid = 0; rx_bits = '0;
    @(negedge clk);
    rstb = 1'b1;
  endtask

  typedef struct {
    bit          en, clr, vld;
    logic [15:0] bits;
    bit          locked, flag;
    longint      err, nbits;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    longint      err_mark;
    bit          saw_unlock;

    rstb = 1'b1; en = 0; clear = 0; rx_valid = 0; rx_bits = '0;
    #2;
    do_reset();

    // An all-zero stream is a valid (degenerate) sequence, so expected counts are easy to derive.
    tbl[0]  = '{0, 0, 0, 16'h0000, 0, 0,  0,  0};
    tbl[1]  = '{1, 0, 0, 16'h0000, 0, 0,  0,  0};
    tbl[2]  = '{1, 0, 1, 16'h0000, 1, 0,  0,  0};
    tbl[3]  = '{1, 0, 1, 16'h0000, 1, 0,  0, 16};
    tbl[4]  = '{1, 0, 1, 16'h0008, 1, 1,  1, 32};
    tbl[5]  = '{1, 0, 0, 16'hFFFF, 1, 0,  1, 32};
    tbl[6]  = '{1, 0, 1, 16'h0000, 1, 0,  1, 48};
    tbl[7]  = '{1, 1, 1, 16'h00FF, 1, 1,  0,  0};
    tbl[8]  = '{1, 0, 1, 16'hFFFF, 1, 1, 16, 16};
    tbl[9]  = '{0, 0, 1, 16'hFFFF, 0, 0, 16, 16};
    tbl[10] = '{1, 0, 1, 16'h0000, 0, 0, 16, 16};
    tbl[11] = '{1, 0, 1, 16'h0034, 1, 0, 16, 16};
    tbl[12] = '{1, 0, 1, 16'h0003, 1, 1, 18, 32};

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].bits);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].locked);
      check($sformatf("tbl%0d_flag", i), err_flag, tbl[i].flag);
      check($sformatf("tbl%0d_err", i), err_cnt, tbl[i].err);
      check($sformatf("tbl%0d_bits", i), bit_cnt, tbl[i].nbits);
    end

    // Clean PRBS7 stream: 100 valid words with random idle gaps.
    do_reset();
    g = 7'($urandom_range(1, 127));
    cycle(1, 0, 0, 16'h0000);
    for (int k = 0; k < 100; ) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle(1, 0, 0, 16'($urandom));
      end else begin
        gen_word(w);
        cycle(1, 0, 1, w);
        k++;
        if (k == 1) check("lock_after_seed", locked, 1);
      end
    end
    check("clean_err_cnt", err_cnt, 0);
    check("clean_bit_cnt", bit_cnt, 1584);
    check("clean_locked", locked, 1);

    // Single flipped bit: one-cycle flag, one error, no propagation.
    gen_word(w);
    w[3] = ~w[3];
    cycle(1, 0, 1, w);
    check("flip_flag", err_flag, 1);
    check("flip_err", err_cnt, 1);
    for (int k = 0; k < 5; k++) begin
      gen_word(w);
      cycle(1, 0, 1, w);
      check("flip_flag_drop", err_flag, 0);
    end
    check("flip_err_final", err_cnt, 1);

    // Clear beats a simultaneous 8-error word; the flag still reports it.
    gen_word(w);
    cycle(1, 1, 1, w ^ 16'h00FF);
    check("clr_err", err_cnt, 0);
    check("clr_bits", bit_cnt, 0);
    check("clr_flag", err_flag, 1);

    // Phase-shifted stream.
    for (int k = 0; k < 5; k++) begin
      logic nb;
      nb = g[0] ^ g[1];
      g  = {nb, g[6:1]};
    end
    err_mark   = 0;
    saw_unlock = 0;
    for (int k = 0; k < 40; k++) begin
      gen_word(w);
      cycle(1, 0, 1, w);
      if (!locked) saw_unlock = 1;
      if (k == 31) err_mark = longint'(err_cnt);
    end
`ifdef PRBS_AUTO_RELOCK_EN
    check("shift_saw_unlock", saw_unlock, 1);
    check("shift_relocked", locked, 1);
    check("shift_err_stable", err_cnt, err_mark);
`else
    check("shift_never_unlock", saw_unlock, 0);
    check("shift_locked", locked, 1);
    check("shift_err_grows", (err_cnt > 0), 1);
`endif

    // Mid-CHECK asynchronous reset, then counter saturation on the narrow instance.
    do_reset();
    cycle(1, 0, 0, 16'h0000);
    cycle(1, 0, 1, 16'h0000);
    for (int k = 0; k < 4; k++) cycle(1, 0, 1, 16'h0007);
    check("sat_pre", s_err_cnt, 12);
    cycle(1, 0, 1, 16'h001F);
    check("sat_err", s_err_cnt, 15);
    check("sat_main_err", err_cnt, 17);
    cycle(1, 0, 1, 16'h001F);
    check("sat_err_hold", s_err_cnt, 15);
    check("sat_bits", s_bit_cnt, 63);

    // Randomized traffic with errors, gaps, clears and enable drops.
    do_reset();
    g = 7'($urandom_range(1, 127));
    for (int k = 0; k < 400; k++) begin
      bit e, c, v;
      e = ($urandom_range(0, 19) != 0);
      c = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = 16'($urandom);
      if (v) begin
        gen_word(w);
        if ($urandom_range(0, 3) == 0) w = w ^ (16'd1 << $urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) w = w ^ 16'($urandom);
      end
      cycle(e, c, v, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
